// File: rtl/multicycle_ctrl_pkg.sv
// rv_ctrl_pkg: shared constants and types for the RV32I multi-cycle controller.
//   - opcode encodings of the supported instruction classes
//   - controller state encoding (also exported on the debug state port)
//   - ALU operation selects
//   - instruction-class decode record and the branch-taken helper
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic illegal;
  } inst_class_t;

  // funct3[0] separates bne (1) from beq (0); only those two are legal.
  function automatic logic branch_taken(input logic funct3_lsb, input logic zero);
    return funct3_lsb ? ~zero : zero;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multi-cycle controller and
// the RV32I datapath / shared memory port.
//   master (controller): reads inst, zero, mem_ready; drives memory request,
//                        datapath strobes/selects, debug state and sticky flags.
//   slave  (datapath/memory side): the mirror image.
interface multicycle_ctrl_if;
  logic [31:0] inst;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_is_fetch;
  logic        ir_write;
  logic        pc_write;
  logic        pc_sel;
  logic        reg_write;
  logic        mem_to_reg;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        illegal;
  logic        timeout;

  modport master (
    input  inst, zero, mem_ready,
    output mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_sel,
           reg_write, mem_to_reg, alu_src, alu_op, state, illegal, timeout
  );

  modport slave (
    output inst, zero, mem_ready,
    input  mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_sel,
           reg_write, mem_to_reg, alu_src, alu_op, state, illegal, timeout
  );
endinterface

// File: rtl/multicycle_ctrl_inst_class.sv
// inst_class: combinational instruction classifier.
//   opcode in  7  inst[6:0]
//   funct3 in  3  inst[14:12]
//   cls    out    one-hot class flags plus illegal (unknown opcode, or a
//                 branch other than beq/bne)
import rv_ctrl_pkg::*;

module inst_class (
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  output inst_class_t cls
);

  // Opcode / funct3 classification.
  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:     cls.is_r     = 1'b1;
      OP_I:     cls.is_i     = 1'b1;
      OP_LOAD:  cls.is_load  = 1'b1;
      OP_STORE: cls.is_store = 1'b1;
      OP_BRANCH: begin
        cls.is_branch = 1'b1;
        if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
          cls.illegal = 1'b0;
        end else begin
          cls.illegal = 1'b1;
        end
      end
      default:  cls.illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I datapath.
//   clk  in  core clock (rising edge)
//   rst  in  asynchronous active-low reset
//   bus  master modport: inst/zero/mem_ready in; memory request, datapath
//        strobes and selects, debug state, sticky illegal/timeout out.
// Strobes are decoded from the registered state and the live inputs so a
// memory handshake completes in the same cycle mem_ready is seen.
import rv_ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             illegal_r, timeout_r;
  logic             set_illegal_s, set_timeout_s;
  logic             cnt_last_s;
  inst_class_t      cls_s;

  logic       mem_req_s, mem_we_s, mem_is_fetch_s, ir_write_s;
  logic       pc_write_s, pc_sel_s, reg_write_s, mem_to_reg_s, alu_src_s;
  logic [1:0] alu_op_s;

  inst_class u_inst_class (
    .opcode (bus.inst[6:0]),
    .funct3 (bus.inst[14:12]),
    .cls    (cls_s)
  );

  // The cycle in which an unanswered request would reach the limit.
  assign cnt_last_s = (cnt_r == CNT_LAST);

  // Next-state and strobe decode.
  always_comb begin
    state_nxt_s    = state_r;
    mem_req_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_is_fetch_s = 1'b0;
    ir_write_s     = 1'b0;
    pc_write_s     = 1'b0;
    pc_sel_s       = 1'b0;
    reg_write_s    = 1'b0;
    mem_to_reg_s   = 1'b0;
    alu_src_s      = 1'b0;
    alu_op_s       = ALUOP_ADD;
    set_illegal_s  = 1'b0;
    set_timeout_s  = 1'b0;
    case (state_r)
      ST_RESET: state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        mem_req_s      = 1'b1;
        mem_is_fetch_s = 1'b1;
        // A response in the limit cycle still wins over the timeout.
        if (bus.mem_ready) begin
          ir_write_s  = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (cnt_last_s) begin
          set_timeout_s = 1'b1;
          state_nxt_s   = ST_HALT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (cls_s.illegal) begin
          set_illegal_s = 1'b1;
          state_nxt_s   = ST_HALT;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_s.is_r) begin
          alu_op_s    = ALUOP_FUNCT;
          state_nxt_s = ST_WB;
        end else if (cls_s.is_i) begin
          alu_src_s   = 1'b1;
          alu_op_s    = ALUOP_FUNCT;
          state_nxt_s = ST_WB;
        end else if (cls_s.is_load || cls_s.is_store) begin
          alu_src_s   = 1'b1;
          state_nxt_s = ST_MEM;
        end else if (cls_s.is_branch) begin
          alu_op_s    = ALUOP_SUB;
          pc_write_s  = 1'b1;
          pc_sel_s    = branch_taken(bus.inst[12], bus.zero);
          state_nxt_s = ST_FETCH;
        end else begin
          // IR changed under us after DECODE: stop rather than guess.
          set_illegal_s = 1'b1;
          state_nxt_s   = ST_HALT;
        end
      end
      ST_MEM: begin
        mem_req_s = 1'b1;
        alu_src_s = 1'b1;
        mem_we_s  = cls_s.is_store;
        if (bus.mem_ready) begin
          if (cls_s.is_store) begin
            // Store retires on the accepting cycle: PC advances to PC+4.
            pc_write_s  = 1'b1;
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_WB;
          end
        end else if (cnt_last_s) begin
          set_timeout_s = 1'b1;
          state_nxt_s   = ST_HALT;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = cls_s.is_load;
        pc_write_s   = 1'b1;
        state_nxt_s  = ST_FETCH;
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_HALT;
    endcase
  end

  // State register, handshake wait counter and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_RESET;
      cnt_r     <= '0;
      illegal_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      illegal_r <= illegal_r | set_illegal_s;
      timeout_r <= timeout_r | set_timeout_s;
      // Any state change clears the counter, so entry to FETCH/MEM starts at 0;
      // staying in FETCH/MEM only happens while mem_ready is low.
      if (state_nxt_s != state_r) begin
        cnt_r <= '0;
      end else if ((state_r == ST_FETCH) || (state_r == ST_MEM)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.mem_req      = mem_req_s;
  assign bus.mem_we       = mem_we_s;
  assign bus.mem_is_fetch = mem_is_fetch_s;
  assign bus.ir_write     = ir_write_s;
  assign bus.pc_write     = pc_write_s;
  assign bus.pc_sel       = pc_sel_s;
  assign bus.reg_write    = reg_write_s;
  assign bus.mem_to_reg   = mem_to_reg_s;
  assign bus.alu_src      = alu_src_s;
  assign bus.alu_op       = alu_op_s;
  assign bus.state        = state_r;
  assign bus.illegal      = illegal_r;
  assign bus.timeout      = timeout_r;

endmodule
